riscv_core_sequencer: RTL

Run-control sequencer between the AXI4-Lite control register file and the RISC-V core. Turns host register writes into single-cycle instruction-memory write strobes, holds the core in reset for a fixed period, then runs it. Run ends on core halt, host abort or optional cycle timeout. Exposes a status word and cycle count for readback through the register file.

---
 rtl/riscv_core_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_core_sequencer.sv
// riscv_core_sequencer: run-control sequencer between the AXI4-Lite control
// registers and the RISC-V core. Turns host writes into one-cycle imem write
// strobes, holds the core in reset for RST_CYCLES, runs it, and stops on halt,
// abort, soft clear or (optionally) a cycle timeout.
//
// Optional feature macro: RUN_TIMEOUT_EN (enables the MAX_CYCLES run limit).
module riscv_core_sequencer #(
    parameter int unsigned IMEM_AW    = 10,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned MAX_CYCLES = 1000000
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    input  logic               mem_reset_n,
    input  logic               run_pc_in,
    input  logic [31:0]        cfg_imem_addr,
    input  logic [31:0]        cfg_imem_data,
    input  logic [31:0]        cfg_cmd,
    input  logic               core_halt,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               core_rst,
    output logic               core_run,
    output logic [31:0]        status,
    output logic [31:0]        cycle_count
);

    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (RST_CYCLES < 1 || MAX_CYCLES < 1) begin : gen_cfg_check
        $error("riscv_core_sequencer: RST_CYCLES and MAX_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StReset = 3'd2,
        StRun   = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_q, run_q;
    logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [31:0]         cnt_q, cnt_d, cnt_inc;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                load_err_q, load_err_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic [IMEM_AW-1:0]  addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rst_q, rst_d;
    logic                run_out_q, run_out_d;

    logic load_evt, run_evt, abort, addr_ok;
    logic unused_cmd_bits;

    assign unused_cmd_bits = ^cfg_cmd[31:2];

    assign load_evt = cfg_cmd[0] ^ cmd_q;
    assign run_evt  = run_pc_in & ~run_q;
    assign abort    = cfg_cmd[1];
    // Word aligned and inside the IMEM_AW word window
    assign addr_ok  = (cfg_imem_addr[1:0] == 2'b00) &&
                      ((cfg_imem_addr >> (IMEM_AW + 2)) == 32'd0);
    assign cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    // Edge-detector history; keeps sampling through both resets so a held
    // level never looks like a fresh edge on release.
    always_ff @(posedge S_AXI_ACLK) begin
        cmd_q <= cfg_cmd[0];
        run_q <= run_pc_in;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        load_err_d = load_err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (run_evt) begin
                    state_d    = StReset;
                    rst_cnt_d  = RstW'(RST_CYCLES - 1);
                    cnt_d      = 32'd0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    // A load colliding with the run request loses and flags an error
                    load_err_d = load_evt;
                end else if (load_evt) begin
                    if (addr_ok) begin
                        state_d = StLoad;
                        we_d    = 1'b1;
                        addr_d  = cfg_imem_addr[IMEM_AW+1:2];
                        wdata_d = cfg_imem_data;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            StReset: begin
                if (load_evt) load_err_d = 1'b1;
                if (abort) begin
                    state_d   = StIdle;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (rst_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q - RstW'(1);
                end
            end
            StRun: begin
                if (load_evt) load_err_d = 1'b1;
                cnt_d = cnt_inc;
                if (abort) begin
                    state_d   = StIdle;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (core_halt) begin
                    state_d = StDone;
                    done_d  = 1'b1;
`ifdef RUN_TIMEOUT_EN
                end else if (cnt_q == 32'(MAX_CYCLES - 1)) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rst_d     = (state_d == StIdle) || (state_d == StLoad) || (state_d == StReset);
        run_out_d = (state_d == StRun);
        busy_d    = (state_d == StReset) || (state_d == StRun);
    end

    // State and output registers; soft clear behaves like the hard reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || !mem_reset_n) begin
            state_q    <= StIdle;
            rst_cnt_q  <= '0;
            cnt_q      <= 32'd0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            load_err_q <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            rst_q      <= 1'b1;
            run_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            load_err_q <= load_err_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rst_q      <= rst_d;
            run_out_q  <= run_out_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign core_rst    = rst_q;
    assign core_run    = run_out_q;
    assign cycle_count = cnt_q;
    assign status      = {25'd0, state_q, load_err_q, timeout_q, done_q, busy_q};

endmodule
